// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: one result buffer per execution unit, one grant per cycle
// Optional feature macro: WB_ARB_RR_EN (round-robin grant; fixed lowest-index priority when undefined)

package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        RF_GPR = 2'd0,
        RF_ROB = 2'd1,
        RF_FPR = 2'd2
    } RegType_t;

    typedef struct packed {
        RegType_t   rtype;
        logic [5:0] addr;
    } RegFile_t;

endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int REQ_NUM = 4,
    parameter int DATA    = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush_,
    input  logic [REQ_NUM-1:0]                req_e_,
    input  RegFile_t [REQ_NUM-1:0]            req_rd,
    input  logic [REQ_NUM-1:0][DATA-1:0]      req_data,
    output logic [REQ_NUM-1:0]                exe_busy,
    output logic                              wb_e_,
    output RegFile_t                          wb_rd,
    output logic [DATA-1:0]                   wb_data,
    output logic [$clog2(REQ_NUM)-1:0]        wb_unit,
    output logic                              ovf
);

    localparam int UW = $clog2(REQ_NUM);

    logic [REQ_NUM-1:0] buf_valid;
    RegFile_t           buf_rd   [REQ_NUM];
    logic [DATA-1:0]    buf_data [REQ_NUM];

    logic               any_valid;
    logic [UW-1:0]      grant_idx;
    logic [REQ_NUM-1:0] grant_oh;
    logic [REQ_NUM-1:0] req_v;
    logic [REQ_NUM-1:0] capture;
    logic [REQ_NUM-1:0] overflow;

    assign any_valid = |buf_valid;

`ifdef WB_ARB_RR_EN
    // rr_ptr is the first index searched, i.e. one past the last grant
    logic [UW-1:0] rr_ptr;
    logic [UW-1:0] rr_cand;
    logic          found;

    always_comb begin
        grant_idx = '0;
        rr_cand   = '0;
        found     = 1'b0;
        for (int k = 0; k < REQ_NUM; k++) begin
            rr_cand = UW'((int'(rr_ptr) + k) % REQ_NUM);
            if (!found && buf_valid[rr_cand]) begin
                found     = 1'b1;
                grant_idx = rr_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (any_valid) begin
            rr_ptr <= (grant_idx == UW'(REQ_NUM - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    // Descending scan so the lowest valid index is the last one written
    always_comb begin
        grant_idx = '0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (buf_valid[k]) begin
                grant_idx = UW'(k);
            end
        end
    end
`endif

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            grant_oh[i] = any_valid && (grant_idx == UW'(i));
        end
    end

    assign req_v    = ~req_e_;
    assign exe_busy = buf_valid & ~grant_oh;
    assign overflow = req_v & exe_busy;
    // A buffer being drained this cycle may be reloaded in the same edge
    assign capture  = req_v & (~buf_valid | grant_oh) & {REQ_NUM{flush_}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= '0;
        end else begin
            for (int i = 0; i < REQ_NUM; i++) begin
                if (!flush_) begin
                    buf_valid[i] <= 1'b0;
                end else if (capture[i]) begin
                    buf_valid[i] <= 1'b1;
                end else if (grant_oh[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_NUM; i++) begin
            if (capture[i]) begin
                buf_rd[i]   <= req_rd[i];
                buf_data[i] <= req_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (|overflow) begin
            ovf <= 1'b1;
        end
    end

    always_comb begin
        wb_e_   = 1'b1;
        wb_rd   = '0;
        wb_data = '0;
        wb_unit = '0;
        if (any_valid) begin
            wb_e_   = 1'b0;
            wb_rd   = buf_rd[grant_idx];
            wb_data = buf_data[grant_idx];
            wb_unit = grant_idx;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter

module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  flush_;
    logic [3:0]            req_e_;
    RegFile_t [3:0]        req_rd;
    logic [3:0][31:0]      req_data;
    logic [3:0]            exe_busy;
    logic                  wb_e_;
    RegFile_t              wb_rd;
    logic [31:0]           wb_data;
    logic [1:0]            wb_unit;
    logic                  ovf;

    int errors = 0;
    int checks = 0;

    wb_arbiter #(.REQ_NUM(4), .DATA(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush_   (flush_),
        .req_e_   (req_e_),
        .req_rd   (req_rd),
        .req_data (req_data),
        .exe_busy (exe_busy),
        .wb_e_    (wb_e_),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .wb_unit  (wb_unit),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic RegFile_t rob(input logic [5:0] a);
        RegFile_t r;
        r.rtype = RF_ROB;
        r.addr  = a;
        return r;
    endfunction

    task automatic present(input int u, input logic [5:0] a, input logic [31:0] d);
        req_e_[u]   = 1'b0;
        req_rd[u]   = rob(a);
        req_data[u] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_e_ = '1;
        flush_ = 1'b1;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        flush_   = 1'b1;
        req_e_   = '1;
        req_rd   = '0;
        req_data = '0;
        #2;
        checks++; if (wb_e_ !== 1'b1) begin errors++; $display("FAIL reset_wb_e: got %b exp 1", wb_e_); end
        checks++; if ({wb_unit, wb_rd, wb_data} !== 42'd0) begin errors++; $display("FAIL reset_wb_fields: got unit=%h rd=%h data=%h exp 0", wb_unit, wb_rd, wb_data); end
        checks++; if (exe_busy !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b exp 0000", exe_busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", ovf); end
        step();
        reset = 1'b0;
        step();
        checks++; if (wb_e_ !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b exp 1", wb_e_); end
    endtask

    task automatic test_single();
        do_reset();
        present(0, 6'd2, 32'h11);
        step();
        req_e_ = '1;
        checks++; if (wb_e_ !== 1'b0) begin errors++; $display("FAIL single_wb_e: got %b exp 0", wb_e_); end
        checks++; if (wb_rd !== rob(6'd2)) begin errors++; $display("FAIL single_rd: got %h exp %h", wb_rd, rob(6'd2)); end
        checks++; if (wb_data !== 32'h11) begin errors++; $display("FAIL single_data: got %h exp 11", wb_data); end
        checks++; if (wb_unit !== 2'd0) begin errors++; $display("FAIL single_unit: got %0d exp 0", wb_unit); end
        checks++; if (exe_busy !== 4'b0000) begin errors++; $display("FAIL single_busy: got %b exp 0000", exe_busy); end
        step();
        checks++; if (wb_e_ !== 1'b1) begin errors++; $display("FAIL single_drain: got %b exp 1", wb_e_); end
    endtask

    task automatic test_three();
        logic [3:0] exp_busy [3];
        exp_busy = '{4'b0110, 4'b0100, 4'b0000};
        do_reset();
        present(0, 6'd3, 32'hA0);
        present(1, 6'd4, 32'hA1);
        present(2, 6'd5, 32'hA2);
        for (int c = 0; c < 3; c++) begin
            step();
            req_e_ = '1;
            checks++;
            if ({wb_e_, wb_unit, wb_rd, wb_data} !== {1'b0, 2'(c), rob(6'(3 + c)), 32'hA0 + 32'(c)}) begin
                errors++;
                $display("FAIL three_wb%0d: got e=%b unit=%0d rd=%h data=%h exp e=0 unit=%0d rd=%h data=%h",
                         c, wb_e_, wb_unit, wb_rd, wb_data, c, rob(6'(3 + c)), 32'hA0 + 32'(c));
            end
            checks++; if (exe_busy !== exp_busy[c]) begin errors++; $display("FAIL three_busy%0d: got %b exp %b", c, exe_busy, exp_busy[c]); end
        end
        step();
        checks++; if (wb_e_ !== 1'b1) begin errors++; $display("FAIL three_drain: got %b exp 1", wb_e_); end
    endtask

    task automatic test_fairness();
        logic [1:0]  exp_unit [5];
        logic [31:0] exp_data [5];
        int n;
`ifdef WB_ARB_RR_EN
        exp_unit = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        exp_data = '{32'hB0, 32'hC0, 32'hB1, 32'hB2, 32'hB3};
`else
        exp_unit = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        exp_data = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hC0};
`endif
        do_reset();
        present(0, 6'd20, 32'hB0);
        present(1, 6'd21, 32'hC0);
        n = 1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c <= 5) begin
                checks++;
                if ({wb_e_, wb_unit, wb_data} !== {1'b0, exp_unit[c-1], exp_data[c-1]}) begin
                    errors++;
                    $display("FAIL fair_wb%0d: got e=%b unit=%0d data=%h exp e=0 unit=%0d data=%h",
                             c, wb_e_, wb_unit, wb_data, exp_unit[c-1], exp_data[c-1]);
                end
            end else begin
                checks++; if (wb_e_ !== 1'b1) begin errors++; $display("FAIL fair_drain: got %b exp 1", wb_e_); end
            end
            req_e_[1] = 1'b1;
            if (n < 4 && !exe_busy[0]) begin
                present(0, 6'd20, 32'hB0 + 32'(n));
                n++;
            end else begin
                req_e_[0] = 1'b1;
            end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fair_ovf: got %b exp 0", ovf); end
    endtask

    task automatic test_overflow();
        do_reset();
        present(0, 6'd6, 32'hD0);
        present(1, 6'd7, 32'hE0);
        step();
        checks++; if ({wb_e_, wb_unit, wb_data} !== {1'b0, 2'd0, 32'hD0}) begin errors++; $display("FAIL ovf_wb0: got e=%b unit=%0d data=%h exp e=0 unit=0 data=d0", wb_e_, wb_unit, wb_data); end
        checks++; if (exe_busy[1] !== 1'b1) begin errors++; $display("FAIL ovf_busy1: got %b exp 1", exe_busy[1]); end
        req_e_[0] = 1'b1;
        present(1, 6'd8, 32'hE1);
        step();
        req_e_ = '1;
        checks++; if ({wb_e_, wb_unit, wb_rd, wb_data} !== {1'b0, 2'd1, rob(6'd7), 32'hE0}) begin errors++; $display("FAIL ovf_kept: got e=%b unit=%0d rd=%h data=%h exp e=0 unit=1 rd=%h data=e0", wb_e_, wb_unit, wb_rd, wb_data, rob(6'd7)); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", ovf); end
        step();
        checks++; if (wb_e_ !== 1'b1) begin errors++; $display("FAIL ovf_dropped: got %b exp 1", wb_e_); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", ovf); end
    endtask

    task automatic test_flush();
        do_reset();
        present(0, 6'd9, 32'hF0);
        present(1, 6'd10, 32'hF1);
        step();
        req_e_ = '1;
        flush_ = 1'b0;
        present(2, 6'd11, 32'hF2);
        #1;
        checks++; if ({wb_e_, wb_unit, wb_data} !== {1'b0, 2'd0, 32'hF0}) begin errors++; $display("FAIL flush_wb: got e=%b unit=%0d data=%h exp e=0 unit=0 data=f0", wb_e_, wb_unit, wb_data); end
        checks++; if (exe_busy !== 4'b0010) begin errors++; $display("FAIL flush_busy_pre: got %b exp 0010", exe_busy); end
        step();
        flush_ = 1'b1;
        req_e_ = '1;
        checks++; if (wb_e_ !== 1'b1) begin errors++; $display("FAIL flush_cleared: got %b exp 1", wb_e_); end
        checks++; if (exe_busy !== 4'b0000) begin errors++; $display("FAIL flush_busy: got %b exp 0000", exe_busy); end
        step();
        checks++; if (wb_e_ !== 1'b1) begin errors++; $display("FAIL flush_after: got %b exp 1", wb_e_); end
    endtask

    task automatic test_async_reset();
        do_reset();
        present(0, 6'd12, 32'h50);
        present(1, 6'd13, 32'h51);
        present(2, 6'd14, 32'h52);
        step();
        req_e_ = '1;
        present(1, 6'd13, 32'h5F);
        step();
        req_e_ = '1;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL areset_ovf_pre: got %b exp 1", ovf); end
        checks++; if (exe_busy !== 4'b0100) begin errors++; $display("FAIL areset_busy_pre: got %b exp 0100", exe_busy); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (wb_e_ !== 1'b1) begin errors++; $display("FAIL areset_wb_e: got %b exp 1", wb_e_); end
        checks++; if (exe_busy !== 4'b0000) begin errors++; $display("FAIL areset_busy: got %b exp 0000", exe_busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL areset_ovf: got %b exp 0", ovf); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL areset_data: got %h exp 0", wb_data); end
        step();
        reset = 1'b0;
        present(3, 6'd15, 32'h60);
        step();
        req_e_ = '1;
        checks++; if ({wb_e_, wb_unit, wb_data} !== {1'b0, 2'd3, 32'h60}) begin errors++; $display("FAIL areset_first: got e=%b unit=%0d data=%h exp e=0 unit=3 data=60", wb_e_, wb_unit, wb_data); end
        step();
        checks++; if (wb_e_ !== 1'b1) begin errors++; $display("FAIL areset_drain: got %b exp 1", wb_e_); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_three();
        test_fairness();
        test_overflow();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
